aes_block_loader: RTL
=====================

Name: aes_block_loader

Overview:
- Byte-serial input front end for the AES datapath; the inbound counterpart of the byte-wise key/ciphertext display sequencer.
- Accepts bytes over a valid/ready handshake and assembles a 128-bit key, then one or more 128-bit plaintext blocks.
- Presents each complete block to the AES core with a one-cycle start pulse, then waits for the core's completion before accepting the next block.
- Sits between the operator/host byte source (switch bank or UART receiver) and the AES circuit's data/key inputs.

Parameters:
- NBYTES, 16, bytes per block. Legal range is 2..16. Block width is 8*NBYTES.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- byte_in  input  8  incoming byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader can accept a byte this cycle.
- key_reload  input  1  single-cycle request to discard the current key and load a new one.
- done_in  input  1  AES core has finished the current block; level or pulse.
- key_out  output  8*NBYTES  last complete key. First byte received maps to bits [8*NBYTES-1 : 8*NBYTES-8].
- data_out  output  8*NBYTES  last complete plaintext block, same byte order as key_out.
- key_valid  output  1  key_out holds a complete key.
- start  output  1  one-cycle pulse: data_out and key_out are stable and ready for the core.
- byte_cnt  output  5  bytes accepted into the block currently being assembled.
- busy  output  1  high in S_START and S_WAIT.

Behaviour:
- States: S_KEY, S_DATA, S_START, S_WAIT.
- Reset values: state=S_KEY; all outputs and internal registers 0 (byte_ready is combinational, so it reads 1 in S_KEY).
- byte_ready=1 in S_KEY and S_DATA, 0 in S_START and S_WAIT.
- A byte is accepted only on a cycle where byte_valid and byte_ready are both 1.
- Accept path: shift register <= {shift[8*NBYTES-9:0], byte_in}, and byte_cnt increments.
- byte_valid with byte_ready=0: the byte is not consumed and no state changes.
- S_KEY, on accepting byte number NBYTES (byte_cnt = NBYTES-1 before the accept):
  - key_out <= assembled value including the current byte;
  - key_valid <= 1; byte_cnt <= 0; next state S_DATA.
- S_DATA, on accepting byte number NBYTES:
  - data_out <= assembled value; byte_cnt <= 0; next state S_START.
- S_START: start=1 for exactly this one cycle; next state S_WAIT unconditionally. done_in is ignored here.
- S_WAIT: hold until done_in=1 is sampled.
  - Next state is S_DATA, with the key retained.
  - If a reload is pending, next state is S_KEY instead, with key_valid <= 0 and the pending flag cleared.
- key_reload in S_KEY or S_DATA:
  - discard the partial block, byte_cnt <= 0, key_valid <= 0, next state S_KEY;
  - key_out keeps its old value until the new key completes.
- key_reload in S_START or S_WAIT: sets the sticky pending flag; honoured at the S_WAIT exit.
- key_reload and a byte accept in the same cycle: the reload wins and the byte is dropped.
- Output stability: key_out and data_out change only on block completion or reset, never mid-assembly.
- Counter: byte_cnt never exceeds NBYTES-1 and wraps to 0 only on block completion.
- reset at any point, including mid-block or in S_WAIT, returns everything to reset values on the next edge. Any start already issued is not re-pulsed.

Test Plan:
- Key load: after reset, feed 16 bytes 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c with byte_valid held high.
  -> key_out = 128'h2b7e151628aed2a6abf7158809cf4f3c.
  -> key_valid rises on the cycle after the 16th accept; state S_DATA; byte_cnt = 0.
- Data load: then feed bytes 00..0f.
  -> data_out = 128'h000102030405060708090a0b0c0d0e0f.
  -> start high for exactly 1 cycle; busy = 1.
  -> byte_ready = 0 until done_in is asserted 5 cycles later; the next cycle returns to S_DATA with the same key_out.
- Backpressure: drive byte_valid=1 with byte 0xff throughout S_WAIT.
  -> byte_cnt stays 0 and data_out is unchanged.
  -> the first accept happens in the cycle after re-entering S_DATA.
- Gaps in valid: toggle byte_valid 1/0 every cycle while loading a key.
  -> same key_out as the first scenario, completed after 31 cycles.
- Abort and deferred reload:
  - pulse key_reload after 7 data bytes -> byte_cnt = 0, state S_KEY, key_valid = 0, key_out unchanged.
  - pulse key_reload in S_WAIT -> on done_in, state goes to S_KEY, not S_DATA.
- Reset mid-block: assert reset after 9 key bytes.
  -> all outputs 0 on the next edge; a fresh 16-byte load then produces the correct key.

Source files
------------

// File: rtl/aes_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : aes_block_loader
// Purpose  : Byte-serial front end for the AES datapath. Assembles a key and
//            then successive plaintext blocks from a valid/ready byte stream,
//            issues a one-cycle start pulse per block and waits for the core
//            to finish before taking more bytes.
// Revision : 1.0 - initial release
// ============================================================================
module aes_block_loader #(
    parameter int NBYTES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  key_reload,
    input  logic                  done_in,
    output logic [8*NBYTES-1:0]   key_out,
    output logic [8*NBYTES-1:0]   data_out,
    output logic                  key_valid,
    output logic                  start,
    output logic [4:0]            byte_cnt,
    output logic                  busy
);

    localparam int         c_W    = 8 * NBYTES;
    localparam logic [4:0] c_LAST = 5'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_KEY   = 2'd0,
        S_DATA  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t           r_state_q,     w_state_d;
    logic [c_W-1:0]   r_shift_q,     w_shift_d;
    logic [c_W-1:0]   r_key_q,       w_key_d;
    logic [c_W-1:0]   r_data_q,      w_data_d;
    logic             r_key_valid_q, w_key_valid_d;
    logic [4:0]       r_byte_cnt_q,  w_byte_cnt_d;
    logic             r_pend_q,      w_pend_d;

    logic             w_ready;
    logic             w_accept;
    logic [c_W-1:0]   w_assembled;

    // Bytes are only taken while assembling; a reload in the same cycle drops the byte.
    assign w_ready     = (r_state_q == S_KEY) || (r_state_q == S_DATA);
    assign w_accept    = byte_valid && w_ready && !key_reload;
    assign w_assembled = {r_shift_q[c_W-9:0], byte_in};

    // Next-state and register update logic for the loader sequencer.
    always_comb begin
        w_state_d     = r_state_q;
        w_shift_d     = r_shift_q;
        w_key_d       = r_key_q;
        w_data_d      = r_data_q;
        w_key_valid_d = r_key_valid_q;
        w_byte_cnt_d  = r_byte_cnt_q;
        w_pend_d      = r_pend_q;

        case (r_state_q)
            S_KEY, S_DATA: begin
                if (key_reload) begin
                    // Abandon the partial block; the old key stays visible until replaced.
                    w_state_d     = S_KEY;
                    w_shift_d     = '0;
                    w_byte_cnt_d  = '0;
                    w_key_valid_d = 1'b0;
                end else if (w_accept) begin
                    w_shift_d = w_assembled;
                    if (r_byte_cnt_q == c_LAST) begin
                        w_byte_cnt_d = '0;
                        if (r_state_q == S_KEY) begin
                            w_key_d       = w_assembled;
                            w_key_valid_d = 1'b1;
                            w_state_d     = S_DATA;
                        end else begin
                            w_data_d  = w_assembled;
                            w_state_d = S_START;
                        end
                    end else begin
                        w_byte_cnt_d = r_byte_cnt_q + 5'd1;
                    end
                end
            end
            S_START: begin
                // done_in is ignored here: the core has not even seen start yet.
                w_state_d = S_WAIT;
                if (key_reload) begin
                    w_pend_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (done_in) begin
                    if (r_pend_q || key_reload) begin
                        w_state_d     = S_KEY;
                        w_key_valid_d = 1'b0;
                        w_pend_d      = 1'b0;
                    end else begin
                        w_state_d = S_DATA;
                    end
                end else if (key_reload) begin
                    w_pend_d = 1'b1;
                end
            end
            default: begin
                w_state_d = S_KEY;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= S_KEY;
            r_shift_q     <= '0;
            r_key_q       <= '0;
            r_data_q      <= '0;
            r_key_valid_q <= 1'b0;
            r_byte_cnt_q  <= '0;
            r_pend_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_shift_q     <= w_shift_d;
            r_key_q       <= w_key_d;
            r_data_q      <= w_data_d;
            r_key_valid_q <= w_key_valid_d;
            r_byte_cnt_q  <= w_byte_cnt_d;
            r_pend_q      <= w_pend_d;
        end
    end

    assign byte_ready = w_ready;
    assign key_out    = r_key_q;
    assign data_out   = r_data_q;
    assign key_valid  = r_key_valid_q;
    assign byte_cnt   = r_byte_cnt_q;
    assign start      = (r_state_q == S_START);
    assign busy       = (r_state_q == S_START) || (r_state_q == S_WAIT);

endmodule
`default_nettype wire
